aes128_dec_ctrl: RTL and testbench

Iterative AES-128 decryption engine with a controller that sequences a single reusable inverse-round datapath over 10 clock cycles. The same controller also expands the cipher key into an 11-entry round-key store. The block replaces the fully unrolled combinational decryptor wherever area matters more than throughput. It sits between a key-load port and a valid/ready ciphertext stream, and produces a valid/ready plaintext stream.

---
 rtl/aes_pkg.sv | 61 ++++++
 rtl/aes_dec_round.sv | 26 ++
 rtl/inv_mix_col.sv | 27 ++
 rtl/inv_shift_row.sv | 16 +
 rtl/inv_sub_byte.sv | 14 +
 rtl/aes128_dec_ctrl.sv | 136 +++++++++++++
 tb/tb_aes128_dec_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 7 files changed

// File: rtl/aes_pkg.sv
// AES-128 shared types, round constants and GF(2^8) S-box arithmetic.
// Pure declarations and functions, no state.
package aes_pkg;

    typedef logic [0:127] block_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYEXP = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } fsm_t;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8); zero maps to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] v;
        v = gf_inv(b);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] t;
        t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

endpackage

// File: rtl/aes_dec_round.sv
// One inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
// Combinational, no flow control.
module aes_dec_round
    import aes_pkg::*;
(
    input  block_t state_i,
    input  block_t key_i,
    input  logic   last_i,
    output block_t state_o
);

    block_t shifted;
    block_t subbed;
    block_t keyed;
    block_t mixed;

    inv_shift_row u_isr (.state_i(state_i), .state_o(shifted));
    inv_sub_byte  u_isb (.state_i(shifted), .state_o(subbed));

    assign keyed = subbed ^ key_i;

    inv_mix_col   u_imc (.state_i(keyed),   .state_o(mixed));

    assign state_o = last_i ? keyed : mixed;

endmodule

// File: rtl/inv_mix_col.sv
// InvMixColumns: each column multiplied by {0e,0b,0d,09} circulant in GF(2^8).
// Combinational, no flow control.
module inv_mix_col
    import aes_pkg::*;
(
    input  block_t state_i,
    output block_t state_o
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = state_i[32*c      +: 8];
        assign a1 = state_i[32*c + 8  +: 8];
        assign a2 = state_i[32*c + 16 +: 8];
        assign a3 = state_i[32*c + 24 +: 8];

        assign state_o[32*c      +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                                       ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        assign state_o[32*c + 8  +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                                       ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        assign state_o[32*c + 16 +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                                       ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        assign state_o[32*c + 24 +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                                       ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end

endmodule

// File: rtl/inv_shift_row.sv
// InvShiftRows: row r of the column-major state rotates right by r bytes.
// Combinational, no flow control.
module inv_shift_row
    import aes_pkg::*;
(
    input  block_t state_i,
    output block_t state_o
);

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign state_o[8*(r + 4*((c + r) % 4)) +: 8] = state_i[8*(r + 4*c) +: 8];
        end
    end

endmodule

// File: rtl/inv_sub_byte.sv
// InvSubBytes: inverse S-box applied to all 16 state bytes.
// Combinational, no flow control.
module inv_sub_byte
    import aes_pkg::*;
(
    input  block_t state_i,
    output block_t state_o
);

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign state_o[8*i +: 8] = inv_sbox(state_i[8*i +: 8]);
    end

endmodule

// File: rtl/aes128_dec_ctrl.sv
// Iterative AES-128 decryptor: key expanded into 11 round keys, then 10 rounds on one datapath.
// Block result held in DONE until out_ready; no input accepted outside IDLE.
module aes128_dec_ctrl
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [0:127] key_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data,
    output logic         key_loaded
);

    fsm_t       fsm_q;
    logic [3:0] cnt_q;
    block_t     rk_q [0:10];
    block_t     blk_q;
    block_t     out_data_q;
    logic       key_ready_q;
    logic       out_valid_q;
    logic       key_loaded_q;

    logic [3:0] kexp_idx;
    logic [3:0] rk_sel;
    logic [7:0] rcon_sel;
    block_t     rk_step_d;
    block_t     rk_rd;
    block_t     blk_d;
    logic       last_d;

    function automatic block_t expand(input block_t prev, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = prev[0  +: 32];
        w1 = prev[32 +: 32];
        w2 = prev[64 +: 32];
        w3 = prev[96 +: 32];
        t  = {w3[23:0], w3[31:24]};
        t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Index guards keep idle-time counter values inside the tables.
    always_comb begin
        kexp_idx  = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        rcon_sel  = (cnt_q == 4'd0 || cnt_q > 4'd10) ? 8'h00 : RCON[cnt_q];
        rk_step_d = expand(rk_q[kexp_idx], rcon_sel);
        rk_sel    = 4'd10 - cnt_q;
        rk_rd     = rk_q[rk_sel];
        last_d    = (cnt_q == 4'd10);
    end

    aes_dec_round u_round (
        .state_i (blk_q),
        .key_i   (rk_rd),
        .last_i  (last_d),
        .state_o (blk_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q        <= IDLE;
            cnt_q        <= 4'd0;
            blk_q        <= '0;
            out_data_q   <= '0;
            key_ready_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            key_loaded_q <= 1'b0;
            for (int i = 0; i < 11; i++) rk_q[i] <= '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (key_valid && key_ready_q) begin
                        rk_q[0]      <= key_in;
                        key_loaded_q <= 1'b0;
                        cnt_q        <= 4'd1;
                        key_ready_q  <= 1'b0;
                        fsm_q        <= KEYEXP;
                    end else if (in_valid && in_ready) begin
                        blk_q       <= in_data ^ rk_q[10];
                        cnt_q       <= 4'd1;
                        key_ready_q <= 1'b0;
                        fsm_q       <= ROUND;
                    end else begin
                        key_ready_q <= 1'b1;
                    end
                end
                KEYEXP: begin
                    rk_q[cnt_q] <= rk_step_d;
                    if (cnt_q == 4'd10) begin
                        key_loaded_q <= 1'b1;
                        key_ready_q  <= 1'b1;
                        fsm_q        <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ROUND: begin
                    blk_q <= blk_d;
                    if (cnt_q == 4'd10) begin
                        out_data_q  <= blk_d;
                        out_valid_q <= 1'b1;
                        fsm_q       <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        key_ready_q <= 1'b1;
                        fsm_q       <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    // A pending key always outranks data in IDLE.
    assign key_ready  = key_ready_q;
    assign in_ready   = key_ready_q & key_loaded_q & ~key_valid;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign key_loaded = key_loaded_q;

endmodule

// File: tb/tb_aes128_dec_ctrl.sv
// Self-checking bench for aes128_dec_ctrl: FIPS-197 vectors, flow control, reset, random blocks.
module tb_aes128_dec_ctrl;

    logic         clk, rst;
    logic         key_valid, key_ready, in_valid, in_ready;
    logic         out_valid, out_ready, key_loaded;
    logic [0:127] key_in, in_data, out_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  sbox  [256];
    logic [7:0]  isbox [256];
    logic [31:0] mw    [44];

    localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    aes128_dec_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_in     (key_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .key_loaded (key_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        while (bb != 8'h00) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // Reference key schedule as 44 words, Rcon generated by repeated doubling.
    task automatic model_key(input logic [127:0] key);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) mw[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = mw[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            mw[i] = mw[i-4] ^ t;
        end
    endtask

    function automatic logic [127:0] rkey(input int n);
        return {mw[4*n], mw[4*n+1], mw[4*n+2], mw[4*n+3]};
    endfunction

    // Textbook InvCipher on a byte array; s[r + 4c] is row r, column c.
    function automatic logic [127:0] model_dec(input logic [127:0] ct);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] k, res;
        k = rkey(10);
        for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            k = rkey(rnd);
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r+4*c] = isbox[s[r + 4*((c + 4 - r) % 4)]] ^ k[127-8*(r+4*c) -: 8];
            if (rnd > 0) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = gmul(t[4*c],8'h0e) ^ gmul(t[4*c+1],8'h0b) ^ gmul(t[4*c+2],8'h0d) ^ gmul(t[4*c+3],8'h09);
                    s[4*c+1] = gmul(t[4*c],8'h09) ^ gmul(t[4*c+1],8'h0e) ^ gmul(t[4*c+2],8'h0b) ^ gmul(t[4*c+3],8'h0d);
                    s[4*c+2] = gmul(t[4*c],8'h0d) ^ gmul(t[4*c+1],8'h09) ^ gmul(t[4*c+2],8'h0e) ^ gmul(t[4*c+3],8'h0b);
                    s[4*c+3] = gmul(t[4*c],8'h0b) ^ gmul(t[4*c+1],8'h0d) ^ gmul(t[4*c+2],8'h09) ^ gmul(t[4*c+3],8'h0e);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic load_key(input string tag, input logic [127:0] key);
        int n;
        bit bad;
        n = 0;
        while (!key_ready && n < 40) begin tick(); n++; end
        key_valid = 1'b1;
        key_in    = key;
        tick();
        key_valid = 1'b0;
        n = 0; bad = 1'b0;
        while (!key_loaded && n < 40) begin
            if (key_ready || in_ready) bad = 1'b1;
            tick();
            n++;
        end
        chk({tag, " key latency"}, 128'(n), 128'(10));
        chk({tag, " keyexp busy"}, 128'(bad), 128'(0));
    endtask

    task automatic run_block(input string tag, input logic [127:0] ct,
                             input logic [127:0] exp, input int hold);
        int n;
        bit bad;
        logic [127:0] held;
        n = 0;
        while (!in_ready && n < 40) begin tick(); n++; end
        chk({tag, " in_ready"}, 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        in_data  = ct;
        tick();
        in_valid = 1'b0;
        n = 0; bad = 1'b0;
        while (!out_valid && n < 40) begin
            if (in_ready || key_ready) bad = 1'b1;
            tick();
            n++;
        end
        chk({tag, " dec latency"}, 128'(n), 128'(10));
        chk({tag, " round busy"}, 128'(bad), 128'(0));
        chk({tag, " out_data"}, out_data, exp);
        held = out_data;
        bad  = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (out_data !== held || in_ready || key_ready || !out_valid) bad = 1'b1;
        end
        if (hold > 0) chk({tag, " stall"}, 128'(bad), 128'(0));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " release"}, 128'(out_valid), 128'(0));
    endtask

    initial begin
        logic [7:0]   p, q, x;
        logic [127:0] rk_key, rk_ct;
        int           n, cyc, hs, res;
        int           hs_cyc [4];
        bit           bad;

        // S-box tables via walking the multiplicative group with generator 3.
        p = 8'h01; q = 8'h01;
        sbox[0] = 8'h63;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);

        rst = 1'b1; key_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        key_in = '0; in_data = '0;
        repeat (3) tick();
        chk("rst key_ready",  128'(key_ready),  128'(0));
        chk("rst in_ready",   128'(in_ready),   128'(0));
        chk("rst out_valid",  128'(out_valid),  128'(0));
        chk("rst out_data",   out_data,         128'(0));
        chk("rst key_loaded", 128'(key_loaded), 128'(0));
        rst = 1'b0;
        tick();
        chk("post-rst key_ready", 128'(key_ready), 128'(1));
        in_valid = 1'b1; in_data = C1_CT;
        #1;
        chk("no-key in_ready", 128'(in_ready), 128'(0));
        in_valid = 1'b0;

        load_key("c1", C1_KEY);
        chk("c1 rk10", dut.rk_q[10], C1_RK10);
        run_block("c1", C1_CT, C1_PT, 0);
        run_block("c1 bp", C1_CT, C1_PT, 20);

        // Key and data offered together: key wins, data follows after expansion.
        key_valid = 1'b1; key_in = B_KEY; in_valid = 1'b1; in_data = B_CT;
        #1;
        chk("prio in_ready", 128'(in_ready), 128'(0));
        tick();
        key_valid = 1'b0;
        n = 0; bad = 1'b0;
        while (!key_loaded && n < 40) begin
            if (in_ready || key_ready) bad = 1'b1;
            tick();
            n++;
        end
        chk("prio key latency", 128'(n), 128'(10));
        chk("prio held off", 128'(bad), 128'(0));
        chk("b rk10", dut.rk_q[10], B_RK10);
        chk("prio data ready", 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        chk("prio dec latency", 128'(n), 128'(10));
        chk("prio out_data", out_data, B_PT);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Reset in the middle of a block.
        load_key("c1 again", C1_KEY);
        in_valid = 1'b1; in_data = C1_CT;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("midrst out_valid",  128'(out_valid),  128'(0));
        chk("midrst out_data",   out_data,         128'(0));
        chk("midrst key_loaded", 128'(key_loaded), 128'(0));
        chk("midrst key_ready",  128'(key_ready),  128'(0));
        chk("midrst rk10",       dut.rk_q[10],     128'(0));
        tick();
        rst = 1'b0;
        in_valid = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (in_ready || out_valid) bad = 1'b1;
        end
        chk("midrst refused", 128'(bad), 128'(0));
        in_valid = 1'b0;
        load_key("reload", C1_KEY);
        run_block("reload", C1_CT, C1_PT, 0);

        // Back-to-back blocks with out_ready held high.
        for (int i = 0; i < 4; i++) hs_cyc[i] = 0;
        out_ready = 1'b1; in_valid = 1'b1; in_data = C1_CT;
        cyc = 0; hs = 0; res = 0;
        while (res < 4 && cyc < 200) begin
            if (out_valid) begin
                chk("b2b out_data", out_data, C1_PT);
                res++;
            end
            if (in_valid && in_ready) begin
                if (hs < 4) hs_cyc[hs] = cyc;
                hs++;
            end
            tick();
            cyc++;
            if (hs >= 4) in_valid = 1'b0;
        end
        out_ready = 1'b0; in_valid = 1'b0;
        chk("b2b results", 128'(res), 128'(4));
        chk("b2b handshakes", 128'(hs), 128'(4));
        for (int i = 1; i < 4; i++) chk("b2b interval", 128'(hs_cyc[i] - hs_cyc[i-1]), 128'(12));

        // Random keys and ciphertexts against the reference model.
        for (int k = 0; k < 3; k++) begin
            rk_key = {$urandom(), $urandom(), $urandom(), $urandom()};
            model_key(rk_key);
            load_key("rand", rk_key);
            chk("rand rk10", dut.rk_q[10], rkey(10));
            for (int b = 0; b < 2; b++) begin
                rk_ct = {$urandom(), $urandom(), $urandom(), $urandom()};
                run_block("rand", rk_ct, model_dec(rk_ct), int'($urandom_range(0, 3)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
